// File: rtl/ucode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: state encoding, macro-op field
// positions, error bit indices and the latched macro-op operand payload.
package ucode_sequencer_pkg;

  localparam int unsigned GPC_W  = 5;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned ADDR_W = SEL_W + GPC_W;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned ERR_W  = 2;

  localparam logic [4:0]        MACRO_PFX = 5'b11110;
  localparam logic [WORD_W-1:0] NOP_WORD  = 32'h0000_0000;

  // macro-op field positions within the fetched word
  localparam int unsigned PFX_HI = 31;
  localparam int unsigned PFX_LO = 27;
  localparam int unsigned SEL_HI = 26;
  localparam int unsigned SEL_LO = 25;
  localparam int unsigned RD_HI  = 24;
  localparam int unsigned RD_LO  = 21;
  localparam int unsigned RS_HI  = 20;
  localparam int unsigned RS_LO  = 17;
  localparam int unsigned RSV_B  = 16;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  // sticky error flags
  localparam int unsigned ERR_OVR = 0;
  localparam int unsigned ERR_OVF = 1;

  // sequence selector codes (remaining codes reserved)
  localparam logic [SEL_W-1:0] SEQ_MULI = 2'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [IMM_W-1:0] imm;
  } mop_t;

  // ROM address is the sequence selector over the ghost PC
  function automatic logic [ADDR_W-1:0] rom_addr_of(input logic [SEL_W-1:0] sel,
                                                    input logic [GPC_W-1:0] gpc);
    return {sel, gpc};
  endfunction

endpackage

// File: rtl/ucode_sequencer.sv
// Microcode sequencer between fetch and decode: detects macro-ops, stalls the PC,
// walks the external ucode ROM by ghost PC and issues each ghost word to decode.
module ucode_sequencer
  import ucode_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [31:0]      instruction,
  input  logic             exe_override,
  input  logic [31:0]      rom_data,
  input  logic             rom_last,
  output logic [GPC_W+1:0] rom_addr,
  output logic [3:0]       mop_rd,
  output logic [3:0]       mop_rs,
  output logic [15:0]      mop_imm,
  output logic [31:0]      issue_instr,
  output logic             issue_valid,
  output logic             pc_stall,
  output logic             ucode_active,
  output logic             ucode_done,
  output logic [1:0]       err_bits
);

  state_t            r_state;
  state_t            w_next_state;
  logic [GPC_W-1:0]  r_gpc;
  logic [GPC_W-1:0]  w_next_gpc;
  logic [SEL_W-1:0]  r_seq_sel;
  logic [SEL_W-1:0]  w_next_sel;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] w_next_addr;
  mop_t              r_mop;
  mop_t              w_mop_in;
  logic [ERR_W-1:0]  r_err;
  logic [ERR_W-1:0]  w_err_set;
  logic              r_pc_stall;
  logic              r_active;
  logic              r_done;
  logic              w_detect;
  logic              w_latch_mop;
  logic [GPC_W-1:0]  w_step;
  logic              w_unused_rsvd;

  // operand fields of a candidate macro-op; bit 16 is a reserved encoding bit
  assign w_mop_in = '{rd:  instruction[RD_HI:RD_LO],
                      rs:  instruction[RS_HI:RS_LO],
                      imm: instruction[IMM_HI:IMM_LO]};
  assign w_unused_rsvd = instruction[RSV_B];

  // index of the ROM step currently on rom_data (ghost PC runs two ahead)
  assign w_step = r_gpc - GPC_W'(2);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (clk_en) begin
      r_state <= w_next_state;
    end
  end

  // next-state, ROM walk and issue selection
  always_comb begin
    w_next_state = r_state;
    w_next_gpc   = r_gpc;
    w_next_sel   = r_seq_sel;
    w_next_addr  = r_rom_addr;
    w_latch_mop  = 1'b0;
    w_err_set    = '0;
    w_detect     = 1'b0;
    issue_instr  = NOP_WORD;
    issue_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        issue_instr = instruction;
        issue_valid = 1'b1;
        // a redirect from execute outranks a macro-op in the same cycle
        if (rst && !exe_override && (instruction[PFX_HI:PFX_LO] == MACRO_PFX)) begin
          w_detect     = 1'b1;
          issue_instr  = NOP_WORD;
          issue_valid  = 1'b0;
          w_latch_mop  = 1'b1;
          w_next_sel   = instruction[SEL_HI:SEL_LO];
          w_next_addr  = rom_addr_of(instruction[SEL_HI:SEL_LO], GPC_W'(0));
          w_next_gpc   = GPC_W'(1);
          w_next_state = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_next_addr  = rom_addr_of(r_seq_sel, r_gpc);
        w_next_gpc   = r_gpc + GPC_W'(1);
        w_next_state = S_STREAM;
      end
      S_STREAM: begin
        issue_instr = rom_data;
        issue_valid = 1'b1;
        w_next_addr = rom_addr_of(r_seq_sel, r_gpc);
        w_next_gpc  = r_gpc + GPC_W'(1);
        if (exe_override) begin
          w_err_set[ERR_OVR] = 1'b1;
          w_next_gpc         = '0;
          w_next_state       = S_IDLE;
        end else if (rom_last) begin
          w_next_state = S_DONE;
        end else if (w_step == '1) begin
          w_err_set[ERR_OVF] = 1'b1;
          w_next_state       = S_DONE;
        end
      end
      S_DONE: begin
        w_next_gpc   = '0;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // nothing reaches decode while the core is held in reset
    if (!rst) begin
      issue_instr = NOP_WORD;
      issue_valid = 1'b0;
    end
  end

  // sequence bookkeeping and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gpc      <= '0;
      r_seq_sel  <= '0;
      r_rom_addr <= '0;
      r_mop      <= '0;
      r_err      <= '0;
      r_pc_stall <= 1'b0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else if (clk_en) begin
      r_gpc      <= w_next_gpc;
      r_seq_sel  <= w_next_sel;
      r_rom_addr <= w_next_addr;
      r_err      <= r_err | w_err_set;
      if (w_latch_mop) begin
        r_mop <= w_mop_in;
      end
      r_pc_stall <= (w_next_state == S_LAUNCH) || (w_next_state == S_STREAM);
      r_active   <= (w_next_state == S_LAUNCH) || (w_next_state == S_STREAM);
      r_done     <= (w_next_state == S_DONE);
    end
  end

  // the detect cycle must hold the PC before the registered stall catches up
  assign pc_stall     = r_pc_stall | w_detect;
  assign ucode_active = r_active;
  assign ucode_done   = r_done;
  assign err_bits     = r_err;
  assign rom_addr     = r_rom_addr;
  assign mop_rd       = r_mop.rd;
  assign mop_rs       = r_mop.rs;
  assign mop_imm      = r_mop.imm;

endmodule
